// File: rtl/glide_pkg.sv
// glide_pkg
// Shared defaults and saturation limits for the int8 matrix-tile datapath.
//   DEF_*        : default geometry/widths used by systolic_quant_pipe
//   INT8_*       : requantizer output clamp limits (64-bit signed so they
//                  compare directly against the 64-bit scaled product)
//   INT32_*      : accumulator saturation limits
//   clamp_shift  : limits an 8-bit shift request to the 0..63 range
package glide_pkg;

  localparam int DEF_ARRAY_SIZE = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_TILE_K     = 16;

  localparam logic signed [63:0] INT8_MAX  = 64'sd127;
  localparam logic signed [63:0] INT8_MIN  = -64'sd128;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;

  // Shifting a 64-bit product by more than 63 has no further effect, so
  // requests beyond that collapse to 63.
  function automatic logic [5:0] clamp_shift(input logic [7:0] sh);
    return (sh > 8'd63) ? 6'd63 : sh[5:0];
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe
// One output-stationary processing element of the systolic grid.
//   clk, reset  : clock, asynchronous active-low reset
//   enable      : advances operands and the partial sum; low freezes the PE
//   flush       : last MAC cycle of the window; publish and restart the sum
//   a_in, b_in  : operands arriving from the left / from above
//   a_out, b_out: registered operands, used by this PE's MAC and forwarded
//                 to the right / downward neighbour
//   sum_out     : window result, held until the next flush
module systolic_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         flush,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] b_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] b_out,
  output logic signed [ACC_WIDTH-1:0]  sum_out
);

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext;
  logic signed [ACC_WIDTH-1:0]    partial;
  logic signed [ACC_WIDTH-1:0]    mac;

  // The MAC consumes the registered operands, so the hop register doubles as
  // this PE's operand latch and the skew grows by one cycle per hop.
  assign product     = a_out * b_out;
  assign product_ext = {{(ACC_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};
  assign mac         = partial + product_ext;

  // Operand pass-through, running partial sum and window flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out   <= '0;
      b_out   <= '0;
      partial <= '0;
      sum_out <= '0;
    end else if (enable) begin
      a_out <= a_in;
      b_out <= b_in;
      if (flush) begin
        sum_out <= mac;
        partial <= '0;
      end else begin
        partial <= mac;
      end
    end
  end

endmodule

// File: rtl/systolic_quant_pipe.sv
// systolic_quant_pipe
// int8 matrix tile datapath: 4x4 output-stationary systolic MAC array ->
// 32-bit saturating tile accumulators -> two-stage requantizer to int8.
//   clk, reset      : clock, asynchronous active-low reset
//   enable          : advances the systolic array (low freezes it)
//   a_in / b_in     : signed row / column operands
//   accum_clear     : zero accumulators and overflow flag (wins over enable)
//   accum_enable    : add the latched window result into the accumulators
//   scale_factor    : unsigned requant multiplier
//   shift_amount    : arithmetic right shift after scaling (clamped to 63)
//   quant_enable    : run the requantizer
//   quant_out       : saturated int8 tile
//   systolic_valid  : pulse when a window result has just been latched
//   accum_overflow  : sticky accumulator saturation flag
//   quant_valid     : quant_enable delayed by the two requant stages
module systolic_quant_pipe
  import glide_pkg::*;
#(
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int TILE_K     = DEF_TILE_K
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] a_in [ARRAY_SIZE],
  input  logic signed [DATA_WIDTH-1:0] b_in [ARRAY_SIZE],
  input  logic                         accum_clear,
  input  logic                         accum_enable,
  input  logic        [ACC_WIDTH-1:0]  scale_factor,
  input  logic        [7:0]            shift_amount,
  input  logic                         quant_enable,
  output logic signed [DATA_WIDTH-1:0] quant_out [ARRAY_SIZE][ARRAY_SIZE],
  output logic                         systolic_valid,
  output logic                         accum_overflow,
  output logic                         quant_valid
);

  localparam int CNT_W = (TILE_K > 1) ? $clog2(TILE_K) : 1;

  logic [CNT_W-1:0]            win_count;
  logic                        flush;
  logic signed [DATA_WIDTH-1:0] a_fwd [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [DATA_WIDTH-1:0] b_fwd [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [ACC_WIDTH-1:0]  systolic_out [ARRAY_SIZE][ARRAY_SIZE];
  logic [ARRAY_SIZE*ARRAY_SIZE-1:0] ovf_hit;
  logic [5:0]                  shift_q;
  logic                        stage1_valid;

  assign flush = (win_count == CNT_W'(TILE_K-1));

  // Window counter shared by every PE; the valid pulse lines up with the
  // cycle in which the freshly flushed sums are visible on systolic_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_count      <= '0;
      systolic_valid <= 1'b0;
    end else begin
      systolic_valid <= enable && flush;
      if (enable) begin
        win_count <= flush ? '0 : win_count + CNT_W'(1);
      end
    end
  end

  // Sticky overflow: any cell saturating on an add sets it, only clear or
  // reset drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accum_overflow <= 1'b0;
    end else if (accum_clear) begin
      accum_overflow <= 1'b0;
    end else if (accum_enable && (|ovf_hit)) begin
      accum_overflow <= 1'b1;
    end
  end

  // Requant control: shift is registered alongside the product so that a
  // shift change and a scale change both take two cycles to show up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q      <= '0;
      stage1_valid <= 1'b0;
      quant_valid  <= 1'b0;
    end else begin
      shift_q      <= clamp_shift(shift_amount);
      stage1_valid <= quant_enable;
      quant_valid  <= stage1_valid;
    end
  end

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_src;
      logic signed [DATA_WIDTH-1:0] b_src;
      logic signed [ACC_WIDTH:0]    sum;
      logic signed [ACC_WIDTH-1:0]  acc;
      logic signed [63:0]           acc_ext;
      logic signed [63:0]           scale_ext;
      logic signed [63:0]           prod_q;
      logic signed [63:0]           shifted;
      logic signed [DATA_WIDTH-1:0] q_next;
      logic signed [DATA_WIDTH-1:0] q_reg;

      // Edge PEs take the raw operands; inner PEs take the neighbour's hop
      // register.
      if (j == 0) begin : g_a_edge
        assign a_src = a_in[i];
      end else begin : g_a_inner
        assign a_src = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_src = b_in[j];
      end else begin : g_b_inner
        assign b_src = b_fwd[i-1][j];
      end

      systolic_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .flush   (flush),
        .a_in    (a_src),
        .b_in    (b_src),
        .a_out   (a_fwd[i][j]),
        .b_out   (b_fwd[i][j]),
        .sum_out (systolic_out[i][j])
      );

      // One extra bit exposes signed overflow: the top two bits disagree.
      assign sum = {acc[ACC_WIDTH-1], acc} + {systolic_out[i][j][ACC_WIDTH-1], systolic_out[i][j]};
      assign ovf_hit[i*ARRAY_SIZE+j] = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);

      // Tile accumulator with clear priority and saturating add.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          acc <= '0;
        end else if (accum_clear) begin
          acc <= '0;
        end else if (accum_enable) begin
          if (ovf_hit[i*ARRAY_SIZE+j]) begin
            acc <= sum[ACC_WIDTH] ? INT32_MIN : INT32_MAX;
          end else begin
            acc <= sum[ACC_WIDTH-1:0];
          end
        end
      end

      // Scale is unsigned, so it is zero-extended before the signed multiply;
      // |acc| < 2^31 and scale < 2^32 keep the product inside 64 bits.
      assign acc_ext   = {{(64-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
      assign scale_ext = {{(64-ACC_WIDTH){1'b0}}, scale_factor};
      assign shifted   = prod_q >>> shift_q;

      always_comb begin
        q_next = shifted[DATA_WIDTH-1:0];
        if (shifted > INT8_MAX) begin
          q_next = INT8_MAX[DATA_WIDTH-1:0];
        end else if (shifted < INT8_MIN) begin
          q_next = INT8_MIN[DATA_WIDTH-1:0];
        end
      end

      // Stage 1 samples every cycle; stage 2 only updates the output while
      // a requant request is in flight, otherwise quant_out holds.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prod_q <= '0;
          q_reg  <= '0;
        end else begin
          prod_q <= acc_ext * scale_ext;
          if (stage1_valid) begin
            q_reg <= q_next;
          end
        end
      end

      assign quant_out[i][j] = q_reg;
    end
  end

endmodule

// File: tb/tb_systolic_quant_pipe.sv
// tb_systolic_quant_pipe
// Self-checking bench: table of single-pass tile vectors with spot values,
// hand sequences for multi-pass, overflow/priority, freeze and reset, and a
// scoreboard of modelled int8 tiles checked whenever quant_valid rises.
module tb_systolic_quant_pipe;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic signed [7:0] a_in [N];
  logic signed [7:0] b_in [N];
  logic              accum_clear;
  logic              accum_enable;
  logic [31:0]       scale_factor;
  logic [7:0]        shift_amount;
  logic              quant_enable;
  logic signed [7:0] quant_out [N][N];
  logic              systolic_valid;
  logic              accum_overflow;
  logic              quant_valid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  longint       accModel [N][N];
  int           curA [N];
  int           curB [N];
  logic [127:0] expQ [$];

  typedef struct packed {
    logic [0:3][7:0] a;
    logic [0:3][7:0] b;
    logic [31:0]     scale;
    logic [7:0]      shift;
    logic [0:3][1:0] ci;
    logic [0:3][1:0] cj;
    logic [0:3][7:0] cv;
  } vec_t;

  vec_t vecs [4];

  systolic_quant_pipe dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .a_in           (a_in),
    .b_in           (b_in),
    .accum_clear    (accum_clear),
    .accum_enable   (accum_enable),
    .scale_factor   (scale_factor),
    .shift_amount   (shift_amount),
    .quant_enable   (quant_enable),
    .quant_out      (quant_out),
    .systolic_valid (systolic_valid),
    .accum_overflow (accum_overflow),
    .quant_valid    (quant_valid)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to time systolic_valid pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] quantModel(input longint acc, input longint sc, input int sh);
    longint p;
    int     s;
    s = (sh > 63) ? 63 : sh;
    p = acc * sc;
    p = p >>> s;
    if (p > 127) return 8'h7F;
    if (p < -128) return 8'h80;
    return p[7:0];
  endfunction

  function automatic longint satAdd(input longint x, input longint y);
    longint s;
    s = x + y;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  task automatic applyStimulus(input logic [0:3][7:0] a, input logic [0:3][7:0] b);
    for (int i = 0; i < N; i++) begin
      a_in[i] = a[i];
      b_in[i] = b[i];
      curA[i] = $signed(a[i]);
      curB[i] = $signed(b[i]);
    end
  endtask

  task automatic clearAcc();
    @(negedge clk);
    accum_clear = 1'b1;
    @(negedge clk);
    accum_clear = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        accModel[i][j] = 0;
  endtask

  task automatic waitPulse(output int at);
    bit found;
    found = 1'b0;
    at    = -1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (systolic_valid) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    checkOutput("pulse_seen", longint'(found), 1);
  endtask

  // Wait long enough for new operands to reach every PE, then skip the
  // window in progress so the next latched result is a clean one.
  task automatic waitCleanWindow();
    int t;
    repeat (5) @(negedge clk);
    waitPulse(t);
    waitPulse(t);
  endtask

  task automatic accumPulse();
    accum_enable = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        accModel[i][j] = satAdd(accModel[i][j], longint'(16) * curA[i] * curB[j]);
    @(negedge clk);
    accum_enable = 1'b0;
  endtask

  task automatic quantIssue(input logic [31:0] sc, input logic [7:0] sh);
    logic [127:0] e;
    scale_factor = sc;
    shift_amount = sh;
    quant_enable = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        e[(i*N+j)*8 +: 8] = quantModel(accModel[i][j], longint'(sc), int'(sh));
    expQ.push_back(e);
    @(negedge clk);
    quant_enable = 1'b0;
    checkOutput("qvalid_lat1", longint'(quant_valid), 0);
    @(negedge clk);
    checkOutput("qvalid_lat2", longint'(quant_valid), 1);
  endtask

  task automatic runOverflow();
    clearAcc();
    applyStimulus({8'd127, 8'd127, 8'd127, 8'd127}, {8'd127, 8'd127, 8'd127, 8'd127});
    waitCleanWindow();
    checkOutput("ovf_before", longint'(accum_overflow), 0);
    accum_enable = 1'b1;
    for (int k = 0; k < 8400; k++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          accModel[i][j] = satAdd(accModel[i][j], longint'(16) * 127 * 127);
      @(negedge clk);
      if (k == 7999) checkOutput("ovf_not_yet", longint'(accum_overflow), 0);
    end
    accum_enable = 1'b0;
    checkOutput("ovf_set", longint'(accum_overflow), 1);
    quantIssue(32'd1, 8'd25);
    checkOutput("ovf_q00", longint'(quant_out[0][0]), 63);
  endtask

  function automatic int countNonZero();
    int c;
    c = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (quant_out[i][j] != 8'sd0) c++;
    return c;
  endfunction

  // Scoreboard: every quant_valid cycle must match the oldest queued tile.
  always @(negedge clk) begin
    if (quant_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected", 1, 0);
      end else begin
        logic [127:0] e;
        e = expQ.pop_front();
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            checkOutput($sformatf("sb_q%0d%0d", i, j), longint'(quant_out[i][j]),
                        longint'($signed(e[(i*N+j)*8 +: 8])));
      end
    end
  end

  initial begin
    int p0, p1, p2, c0;

    vecs[0] = '{a: {8'd1, 8'd2, 8'd3, 8'd4}, b: {8'd1, 8'd2, 8'd3, 8'd4},
                scale: 32'd1, shift: 8'd0,
                ci: {2'd0, 2'd0, 2'd1, 2'd2}, cj: {2'd0, 2'd1, 2'd1, 2'd2},
                cv: {8'd16, 8'd32, 8'd64, 8'd127}};
    vecs[1] = '{a: {8'd10, 8'd10, 8'd10, 8'd10}, b: {8'd10, 8'd10, 8'd10, 8'd10},
                scale: 32'd2, shift: 8'd0,
                ci: {2'd0, 2'd1, 2'd3, 2'd2}, cj: {2'd0, 2'd2, 2'd3, 2'd0},
                cv: {8'd127, 8'd127, 8'd127, 8'd127}};
    vecs[2] = '{a: {8'd10, 8'd10, 8'd10, 8'd10}, b: {8'd10, 8'd10, 8'd10, 8'd10},
                scale: 32'd1, shift: 8'd4,
                ci: {2'd0, 2'd3, 2'd1, 2'd2}, cj: {2'd0, 2'd3, 2'd2, 2'd1},
                cv: {8'd100, 8'd100, 8'd100, 8'd100}};
    vecs[3] = '{a: {-8'sd5, 8'sd3, -8'sd2, 8'sd4}, b: {8'sd4, -8'sd3, 8'sd2, -8'sd1},
                scale: 32'd1, shift: 8'd0,
                ci: {2'd0, 2'd0, 2'd1, 2'd2}, cj: {2'd0, 2'd3, 2'd1, 2'd3},
                cv: {8'h80, 8'd80, 8'h80, 8'd32}};

    reset        = 1'b0;
    enable       = 1'b1;
    accum_clear  = 1'b0;
    accum_enable = 1'b0;
    quant_enable = 1'b0;
    scale_factor = 32'd1;
    shift_amount = 8'd0;
    applyStimulus('0, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        accModel[i][j] = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_qout_nonzero", longint'(countNonZero()), 0);
    checkOutput("rst_sys_valid", longint'(systolic_valid), 0);
    checkOutput("rst_ovf", longint'(accum_overflow), 0);
    checkOutput("rst_qvalid", longint'(quant_valid), 0);
    reset = 1'b1;
    c0 = cyc;
    waitPulse(p0);
    checkOutput("first_window_len", longint'(p0 - c0), 16);
    quantIssue(32'd1, 8'd0);

    // Table-driven single-pass tiles.
    for (int k = 0; k < 4; k++) begin
      $display("[TB] vector %0d", k);
      clearAcc();
      applyStimulus(vecs[k].a, vecs[k].b);
      waitCleanWindow();
      accumPulse();
      quantIssue(vecs[k].scale, vecs[k].shift);
      for (int n = 0; n < 4; n++)
        checkOutput($sformatf("vec%0d_q%0d%0d", k, vecs[k].ci[n], vecs[k].cj[n]),
                    longint'(quant_out[vecs[k].ci[n]][vecs[k].cj[n]]),
                    longint'($signed(vecs[k].cv[n])));
    end

    // Overflow, then clear colliding with enable.
    $display("[TB] overflow and clear priority");
    runOverflow();
    @(negedge clk);
    accum_clear  = 1'b1;
    accum_enable = 1'b1;
    @(negedge clk);
    accum_clear  = 1'b0;
    accum_enable = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        accModel[i][j] = 0;
    checkOutput("prio_ovf_cleared", longint'(accum_overflow), 0);
    quantIssue(32'd1, 8'd0);
    checkOutput("prio_q00", longint'(quant_out[0][0]), 0);

    // Freeze: ten disabled cycles stretch one window by exactly ten.
    $display("[TB] freeze");
    applyStimulus({8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1});
    waitPulse(p0);
    waitPulse(p1);
    checkOutput("window_len", longint'(p1 - p0), 16);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    waitPulse(p2);
    checkOutput("frozen_window_len", longint'(p2 - p1), 26);

    // Multi-pass accumulation over tiled K.
    $display("[TB] multi-pass");
    clearAcc();
    applyStimulus({8'd2, 8'd2, 8'd2, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3});
    waitCleanWindow();
    accumPulse();
    applyStimulus({8'd1, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2});
    waitCleanWindow();
    accumPulse();
    applyStimulus({8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1});
    waitCleanWindow();
    accumPulse();
    quantIssue(32'd1, 8'd0);
    checkOutput("mp_shift0_q00", longint'(quant_out[0][0]), 127);
    quantIssue(32'd1, 8'd1);
    checkOutput("mp_shift1_q00", longint'(quant_out[0][0]), 72);
    checkOutput("mp_shift1_q33", longint'(quant_out[3][3]), 72);

    // Reset in the middle of a window with overflow set and output nonzero.
    $display("[TB] reset mid-window");
    runOverflow();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_qout_nonzero", longint'(countNonZero()), 0);
    checkOutput("midrst_sys_valid", longint'(systolic_valid), 0);
    checkOutput("midrst_ovf", longint'(accum_overflow), 0);
    checkOutput("midrst_qvalid", longint'(quant_valid), 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        accModel[i][j] = 0;
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    waitPulse(p0);
    checkOutput("midrst_window_len", longint'(p0 - c0), 16);
    quantIssue(32'd1, 8'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", longint'(expQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
